// File: rtl/mmul_dim_checker.sv
// ============================================================================
// Module   : mmul_dim_checker
// Brief    : Validates matmul job descriptors (RA,CA,RB,CB) and computes the
//            MAC count RA*CA*CB with a serial shift-add multiplier.
//            Optional MMUL_CHK_STATS_EN adds saturating ok/err result counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmul_dim_checker #(
    parameter int DIM_W   = 8,
    parameter int MAX_DIM = 64,
    parameter int OPS_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM_W-1:0] in_ra,
    input  logic [DIM_W-1:0] in_ca,
    input  logic [DIM_W-1:0] in_rb,
    input  logic [DIM_W-1:0] in_cb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [3:0]       out_err,
    output logic [OPS_W-1:0] out_ops
`ifdef MMUL_CHK_STATS_EN
    ,
    output logic [15:0]      stat_ok_cnt,
    output logic [15:0]      stat_err_cnt
`endif
);

    localparam int             c_PW      = 3 * DIM_W;
    localparam int             c_CNT_W   = (DIM_W > 1) ? $clog2(DIM_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(DIM_W - 1);
    localparam logic [DIM_W-1:0]   c_MAX_DIM = DIM_W'(MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_MUL1  = 3'd2,
        S_MUL2  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [DIM_W-1:0]   r_ra;
    logic [DIM_W-1:0]   r_ca;
    logic [DIM_W-1:0]   r_rb;
    logic [DIM_W-1:0]   r_cb;
    logic [c_PW-1:0]    r_acc;
    logic [c_PW-1:0]    r_mcand;
    logic [DIM_W-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_err;
    logic [OPS_W-1:0]   r_ops;
    logic               r_ok;

    logic [2:0]         w_err_dim;
    logic [c_PW-1:0]    w_step;
    logic               w_last;
    logic               w_ovf;
    logic               w_hs;

    assign w_err_dim[0] = (r_ca != r_rb);
    assign w_err_dim[1] = (r_ra == '0) || (r_ca == '0) || (r_rb == '0) || (r_cb == '0);
    assign w_err_dim[2] = (r_ra > c_MAX_DIM) || (r_ca > c_MAX_DIM) ||
                          (r_rb > c_MAX_DIM) || (r_cb > c_MAX_DIM);

    // One shift-add iteration; on the final iteration this is the full product.
    assign w_step = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last = (r_cnt == c_LAST);
    assign w_ovf  = |(w_step >> OPS_W);
    assign w_hs   = (r_state == S_DONE) && out_ready;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_ok    = r_ok;
    assign out_err   = r_err;
    assign out_ops   = r_ops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_next = S_CHECK;
            S_CHECK: w_next = (|w_err_dim) ? S_DONE : S_MUL1;
            S_MUL1:  if (w_last)      w_next = S_MUL2;
            S_MUL2:  if (w_last)      w_next = S_DONE;
            S_DONE:  if (out_ready)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra     <= '0;
            r_ca     <= '0;
            r_rb     <= '0;
            r_cb     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_ops    <= '0;
            r_ok     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ra <= in_ra;
                        r_ca <= in_ca;
                        r_rb <= in_rb;
                        r_cb <= in_cb;
                    end
                end
                S_CHECK: begin
                    r_err    <= {1'b0, w_err_dim};
                    r_ops    <= '0;
                    r_ok     <= 1'b0;
                    r_acc    <= '0;
                    r_mcand  <= c_PW'(r_ra);
                    r_mplier <= r_ca;
                    r_cnt    <= '0;
                end
                S_MUL1: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // p1 becomes the multiplicand for the second pass by CB.
                        r_acc    <= '0;
                        r_mcand  <= w_step;
                        r_mplier <= r_cb;
                        r_cnt    <= '0;
                    end else begin
                        r_acc    <= w_step;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                S_MUL2: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc    <= w_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        if (w_ovf) begin
                            r_err[3] <= 1'b1;
                            r_ops    <= '1;
                            r_ok     <= 1'b0;
                        end else begin
                            r_ops    <= w_step[OPS_W-1:0];
                            r_ok     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_err <= '0;
                        r_ops <= '0;
                        r_ok  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MMUL_CHK_STATS_EN
    logic [15:0] r_stat_ok;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ok  <= '0;
            r_stat_err <= '0;
        end else if (w_hs) begin
            if (r_ok) begin
                if (r_stat_ok != 16'hFFFF) r_stat_ok <= r_stat_ok + 16'd1;
            end else begin
                if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
            end
        end
    end

    assign stat_ok_cnt  = r_stat_ok;
    assign stat_err_cnt = r_stat_err;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmul_dim_checker.sv
// ============================================================================
// Module   : tb_mmul_dim_checker
// Brief    : Directed self-checking bench for mmul_dim_checker with an
//            arithmetic reference model and a per-cycle output monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmul_dim_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ra, in_ca, in_rb, in_cb;
    logic        out_valid;
    logic        out_ready;
    logic        out_ok;
    logic [3:0]  out_err;
    logic [15:0] out_ops;
`ifdef MMUL_CHK_STATS_EN
    logic [15:0] stat_ok_cnt;
    logic [15:0] stat_err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int n_ok  = 0;
    int n_err = 0;

    logic [3:0]  exp_err;
    logic [15:0] exp_ops;
    logic        exp_ok;

    mmul_dim_checker #(.DIM_W(8), .MAX_DIM(64), .OPS_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ra     (in_ra),
        .in_ca     (in_ca),
        .in_rb     (in_rb),
        .in_cb     (in_cb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ok    (out_ok),
        .out_err   (out_err),
        .out_ops   (out_ops)
`ifdef MMUL_CHK_STATS_EN
        ,
        .stat_ok_cnt  (stat_ok_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, act, req, $time);
        end
    endtask

    // Reference model: straight from the dimension rules and plain multiplication.
    task automatic model(input int ra, input int ca, input int rb, input int cb,
                         output logic [3:0] e, output logic [15:0] ops, output logic ok);
        longint prod;
        e = 4'b0000;
        e[0] = (ca != rb);
        e[1] = (ra == 0) || (ca == 0) || (rb == 0) || (cb == 0);
        e[2] = (ra > 64) || (ca > 64) || (rb > 64) || (cb > 64);
        ops = 16'd0;
        if (e[2:0] == 3'b000) begin
            prod = longint'(ra) * longint'(ca) * longint'(cb);
            if (prod >= 65536) begin
                e[3] = 1'b1;
                ops  = 16'hFFFF;
            end else begin
                ops = prod[15:0];
            end
        end
        ok = (e == 4'b0000);
    endtask

    // Monitor: every cycle a result is presented it must match the model and stay put.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("mon_err", out_err, exp_err);
            check("mon_ops", out_ops, exp_ops);
            check("mon_ok",  out_ok,  exp_ok);
            check("mon_in_ready_low", in_ready, 0);
        end
    end

    task automatic accept(input int ra, input int ca, input int rb, input int cb);
        int w;
        logic [3:0]  e;
        logic [15:0] o;
        logic        k;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        model(ra, ca, rb, cb, e, o, k);
        exp_err  = e;
        exp_ops  = o;
        exp_ok   = k;
        in_valid = 1'b1;
        in_ra = 8'(ra); in_ca = 8'(ca); in_rb = 8'(rb); in_cb = 8'(cb);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ra = 8'($urandom); in_ca = 8'($urandom);
        in_rb = 8'($urandom); in_cb = 8'($urandom);
    endtask

    task automatic run_job(input int ra, input int ca, input int rb, input int cb,
                           input int lat, input int lerr, input int lops, input int hold);
        int n;
        out_ready = (hold == 0);
        accept(ra, ca, rb, cb);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("lit_err", out_err, lerr);
        check("lit_ops", out_ops, lops);
        check("lit_ok",  out_ok, (lerr == 0));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_valid", out_valid, 0);
        if (lerr == 0) n_ok++; else n_err++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ra = '0; in_ca = '0; in_rb = '0; in_cb = '0;
        exp_err = '0; exp_ops = '0; exp_ok = 1'b0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_ok",    out_ok, 0);
        check("rst_err",   out_err, 0);
        check("rst_ops",   out_ops, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(4, 3, 3, 5,     17, 4'b0000, 60,     0);
        run_job(1, 3, 4, 1,      1, 4'b0001, 0,      0);
        run_job(1, 70, 3, 1,     1, 4'b0101, 0,      0);
        run_job(0, 2, 2, 1,      1, 4'b0010, 0,      0);
        run_job(65, 1, 1, 1,     1, 4'b0100, 0,      0);
        run_job(64, 64, 64, 64, 17, 4'b1000, 16'hFFFF, 0);
        run_job(40, 40, 40, 40, 17, 4'b0000, 64000,  0);
        run_job(7, 9, 9, 11,    17, 4'b0000, 693,    5);
        run_job(2, 2, 2, 2,     17, 4'b0000, 8,      0);
        run_job(255, 255, 255, 255, 1, 4'b0100, 0,   0);

        // Asynchronous reset in the middle of the first multiply pass.
        out_ready = 1'b1;
        accept(5, 5, 5, 5);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_ops",   out_ops, 0);
        n_ok = 0; n_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            check("midrst_no_result", out_valid, 0);
        end

        run_job(3, 3, 3, 3,     17, 4'b0000, 27,     0);
        run_job(1, 2, 3, 4,      1, 4'b0001, 0,      0);
        run_job(64, 1, 1, 64,   17, 4'b0000, 4096,   0);
        run_job(1, 0, 0, 1,      1, 4'b0010, 0,      0);
        run_job(64, 64, 64, 15, 17, 4'b0000, 61440,  0);
`ifdef MMUL_CHK_STATS_EN
        check("stat_ok",  stat_ok_cnt,  n_ok);
        check("stat_err", stat_err_cnt, n_err);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mmul_dim_checker.md
# mmul_dim_checker

Runtime successor to the elaboration-time dimension check for matrix-multiply jobs. It accepts a job descriptor (RA, CA, RB, CB) over a valid/ready handshake. It flags dimension mismatch, zero, out-of-range and op-count-overflow errors, and computes the MAC count RA·CA·CB with a serial shift-add multiplier. It sits in front of the mmul job scheduler and gates which descriptors are dispatched.

## Interface

- DIM_W, 8: width of each dimension field.
- MAX_DIM, 64: largest legal value of any dimension.
- OPS_W, 16: width of the ops result; must be ≤ 3·DIM_W.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  block can accept a descriptor.
- in_ra, in_ca, in_rb, in_cb  input  DIM_W each  dimensions.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_ok  output  1  high when out_err == 0.
- out_err  output  4  bit0 CA≠RB; bit1 any dim zero; bit2 any dim > MAX_DIM; bit3 RA·CA·CB ≥ 2^OPS_W.
- out_ops  output  OPS_W  MAC count. Saturates to all-ones on overflow. Zero if bits 0–2 of out_err are set.
- stat_ok_cnt, stat_err_cnt  output  16 each  present only with MMUL_CHK_STATS_EN.

## Operation

- States: IDLE, CHECK, MUL1, MUL2, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: register all four dims and go to CHECK.
- CHECK (one cycle)
  - Evaluate err bits 0–2; all applicable bits are set together, with no priority.
  - If any is set: out_ops = 0, go to DONE.
  - Otherwise go to MUL1.
- MUL1
  - DIM_W iterations of shift-add; p1 (2·DIM_W bits) = RA·CA.
  - An iteration counter is cleared on entry.
  - Go to MUL2 after the last iteration.
- MUL2
  - DIM_W iterations; p2 (3·DIM_W bits) = p1·CB.
  - Go to DONE.
  - On exit: if p2[3·DIM_W-1:OPS_W] ≠ 0, set bit3 and out_ops = all-ones; otherwise out_ops = p2[OPS_W-1:0].
- DONE
  - out_valid = 1.
  - out_ok, out_err and out_ops are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0 in every state except IDLE, so a new descriptor is never accepted in the cycle the result is taken.
- Dimension inputs are sampled only at the accepting edge. Later changes are ignored.
- Reset (any time, including mid-multiply):
  - All state clears immediately and the FSM goes to IDLE.
  - out_valid = 0, out_ok = 0, out_err = 0, out_ops = 0, in_ready = 1 while rst_n is high in IDLE.
  - Stat counters clear to 0.

## Timing

- The accepting edge is edge 0.
- Error path: DONE is entered at edge 1, so out_valid is high after edge 1.
- Good path: out_valid is high after edge 2·DIM_W+1 (17 for DIM_W = 8).
- The result is held indefinitely while out_ready = 0.
- The handshake completes at the edge where out_valid && out_ready. in_ready rises after that edge.
- Throughput: one descriptor per 2·DIM_W+3 cycles at best on the good path, and one per 3 cycles on the error path.
- out_* are registered with no combinational path from the inputs. in_ready is decoded from state only.

## Configuration

- MMUL_CHK_STATS_EN defined:
  - Adds stat_ok_cnt and stat_err_cnt.
  - On each output handshake, increment the counter selected by out_ok.
  - Counters saturate at 0xFFFF and clear on reset.
- MMUL_CHK_STATS_EN undefined:
  - The ports and counters are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use DIM_W = 8, MAX_DIM = 64, OPS_W = 16.

- RA=4, CA=3, RB=3, CB=5 with out_ready = 1 → out_valid after 17 edges; out_ops = 60, out_err = 0, out_ok = 1.
- CA=3, RB=4 → out_valid after 1 edge; out_err = 0b0001, out_ops = 0. CA=70, RB=3 → out_err = 0b0101.
- RA=0, CA=RB=2, CB=1 → out_err = 0b0010. RA=65, CA=RB=CB=1 → out_err = 0b0100.
- RA=CA=RB=CB=64 → product 262144 → out_err = 0b1000, out_ops = 0xFFFF, out_ok = 0. RA=CA=RB=CB=40 → out_ops = 64000, out_err = 0.
- Good job with out_ready held low 5 cycles → outputs stable and in_ready = 0 throughout. Raise out_ready → handshake; in_ready = 1 the next cycle; a back-to-back descriptor is accepted.
- Assert rst_n = 0 during MUL1 → out_valid = 0 and in_ready = 1 immediately. Then 3 ok jobs and 2 error jobs with MMUL_CHK_STATS_EN → stat_ok_cnt = 3, stat_err_cnt = 2.
